// File: rtl/ascon_pkg.sv
// Shared ASCON definitions: state layout, FSM encoding, round constants and
// the single-round function.
package ascon_pkg;

    localparam int unsigned LANE_W     = 64;
    localparam int unsigned STATE_W    = 5 * LANE_W;
    localparam int unsigned RIDX_W     = 4;
    localparam int unsigned NR_W       = 4;
    localparam int unsigned RC_W       = 8;
    localparam int unsigned MAX_ROUNDS = 12;

    localparam logic [NR_W-1:0] NR_12 = 4'd12;
    localparam logic [NR_W-1:0] NR_8  = 4'd8;
    localparam logic [NR_W-1:0] NR_6  = 4'd6;

    // x0 occupies the most significant lane, matching the flat 320-bit bus.
    typedef struct packed {
        logic [LANE_W-1:0] x0;
        logic [LANE_W-1:0] x1;
        logic [LANE_W-1:0] x2;
        logic [LANE_W-1:0] x3;
        logic [LANE_W-1:0] x4;
    } ascon_state_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } fsm_t;

    localparam logic [RC_W-1:0] ROUND_CONST [MAX_ROUNDS] = '{
        8'hF0, 8'hE1, 8'hD2, 8'hC3, 8'hB4, 8'hA5,
        8'h96, 8'h87, 8'h78, 8'h69, 8'h5A, 8'h4B
    };

    function automatic logic [LANE_W-1:0] ror(input logic [LANE_W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (LANE_W - n));
    endfunction

    // One full round: constant addition, S-box layer, linear diffusion.
    function automatic ascon_state_t ascon_round(input ascon_state_t s, input logic [RIDX_W-1:0] r);
        logic [LANE_W-1:0] x0, x1, x2, x3, x4;
        logic [LANE_W-1:0] t0, t1, t2, t3, t4;
        logic [RC_W-1:0]   rc;
        ascon_state_t      res;
        rc = (r < RIDX_W'(MAX_ROUNDS)) ? ROUND_CONST[r] : RC_W'(0);
        x0 = s.x0;
        x1 = s.x1;
        x2 = s.x2 ^ LANE_W'(rc);
        x3 = s.x3;
        x4 = s.x4;
        x0 = x0 ^ x4;
        x4 = x4 ^ x3;
        x2 = x2 ^ x1;
        t0 = ~x0 & x1;
        t1 = ~x1 & x2;
        t2 = ~x2 & x3;
        t3 = ~x3 & x4;
        t4 = ~x4 & x0;
        x0 = x0 ^ t1;
        x1 = x1 ^ t2;
        x2 = x2 ^ t3;
        x3 = x3 ^ t4;
        x4 = x4 ^ t0;
        x1 = x1 ^ x0;
        x0 = x0 ^ x4;
        x3 = x3 ^ x2;
        x2 = ~x2;
        res.x0 = x0 ^ ror(x0, 19) ^ ror(x0, 28);
        res.x1 = x1 ^ ror(x1, 61) ^ ror(x1, 39);
        res.x2 = x2 ^ ror(x2, 1)  ^ ror(x2, 6);
        res.x3 = x3 ^ ror(x3, 10) ^ ror(x3, 17);
        res.x4 = x4 ^ ror(x4, 7)  ^ ror(x4, 41);
        return res;
    endfunction

endpackage

// File: rtl/ascon_permutation_core_round.sv
// Purely combinational single ASCON round; chained UNROLL times by the core.
module ascon_round
    import ascon_pkg::*;
(
    input  logic [STATE_W-1:0] i_state,
    input  logic [RIDX_W-1:0]  i_ridx,
    output logic [STATE_W-1:0] o_state_c
);

    ascon_state_t w_in;
    ascon_state_t w_out;

    assign w_in      = ascon_state_t'(i_state);
    assign w_out     = ascon_pkg::ascon_round(w_in, i_ridx);
    assign o_state_c = STATE_W'(w_out);

endmodule

// File: rtl/ascon_permutation_core.sv
// Iterative ASCON permutation (p12/p8/p6) with UNROLL rounds per clock and a
// valid/ready handshake on both sides.
module ascon_permutation_core
    import ascon_pkg::*;
#(
    parameter int unsigned UNROLL = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [STATE_W-1:0] in_state,
    input  logic [NR_W-1:0]    in_nrounds,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [STATE_W-1:0] out_state,
    output logic               out_err
);

    if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
        $fatal(1, "ascon_permutation_core: UNROLL must be 1 or 2");
    end

    fsm_t               r_fsm,       w_fsm_next;
    logic [RIDX_W-1:0]  r_ridx,      w_ridx_next;
    logic [STATE_W-1:0] r_state,     w_state_next;
    logic               r_err,       w_err_next;
    logic               r_out_valid, w_out_valid_next;
    logic               w_accept;
    logic               w_legal;
    logic [RIDX_W-1:0]  w_ridx_inc;
    logic [STATE_W-1:0] w_chain [UNROLL+1];

    // Round chain: instance k works on round index r+k.
    assign w_chain[0] = r_state;
    for (genvar k = 0; k < UNROLL; k++) begin : g_round
        logic [RIDX_W-1:0] w_ridx_k;
        assign w_ridx_k = r_ridx + RIDX_W'(k);
        ascon_round u_round (
            .i_state   (w_chain[k]),
            .i_ridx    (w_ridx_k),
            .o_state_c (w_chain[k+1])
        );
    end

    assign in_ready   = (r_fsm == ST_IDLE) | ((r_fsm == ST_DONE) & out_ready);
    assign w_accept   = in_valid & in_ready;
    assign w_legal    = (in_nrounds == NR_12) | (in_nrounds == NR_8) | (in_nrounds == NR_6);
    assign w_ridx_inc = r_ridx + RIDX_W'(UNROLL);

    always_comb begin
        w_fsm_next       = r_fsm;
        w_ridx_next      = r_ridx;
        w_state_next     = r_state;
        w_err_next       = r_err;
        w_out_valid_next = r_out_valid;
        case (r_fsm)
            ST_RUN: begin
                w_state_next = w_chain[UNROLL];
                w_ridx_next  = w_ridx_inc;
                if (w_ridx_inc == RIDX_W'(MAX_ROUNDS)) begin
                    w_fsm_next       = ST_DONE;
                    w_out_valid_next = 1'b1;
                end
            end
            ST_DONE: begin
                if (out_ready) begin
                    w_fsm_next       = ST_IDLE;
                    w_out_valid_next = 1'b0;
                    w_err_next       = 1'b0;
                end
            end
            default: ;
        endcase
        // A new request overrides the drain, giving a bubble-free handoff.
        if (w_accept) begin
            w_state_next = in_state;
            if (w_legal) begin
                w_fsm_next       = ST_RUN;
                w_ridx_next      = RIDX_W'(MAX_ROUNDS) - in_nrounds;
                w_err_next       = 1'b0;
                w_out_valid_next = 1'b0;
            end else begin
                w_fsm_next       = ST_DONE;
                w_ridx_next      = '0;
                w_err_next       = 1'b1;
                w_out_valid_next = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fsm       <= ST_IDLE;
            r_ridx      <= '0;
            r_state     <= '0;
            r_err       <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            r_fsm       <= w_fsm_next;
            r_ridx      <= w_ridx_next;
            r_state     <= w_state_next;
            r_err       <= w_err_next;
            r_out_valid <= w_out_valid_next;
        end
    end

    assign out_valid = r_out_valid;
    assign out_state = r_state;
    assign out_err   = r_err;

endmodule
